// File: rtl/decode_ctrl_stage.sv
// Decode-stage control unit: decodes opcode/funct/rt into the control
// bundle and registers it toward ID/EX, with HI/LO interlock and trap squash.
// Ports: clock/reset (async high); instr_valid, opcode, funct, reg_rt_id,
//   instr_shamt, stall_in, flush in; stall_out (comb), ctrl_valid and the
//   registered control/branch bits, hilo_busy, md_done out.
// Optional macro CTRL_ILLEGAL_TRAP_EN: unrecognised instructions trap.
module decode_ctrl_stage #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int TRAP_SQUASH = 1,
    parameter int CNT_W       = $clog2(DIV_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] reg_rt_id,
    input  logic [4:0] instr_shamt,
    input  logic       stall_in,
    input  logic       flush,
    output logic       stall_out,
    output logic       ctrl_valid,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       alu_src,
    output logic       reg_dest,
    output logic       is_byte,
    output logic       syscall,
    output logic       imm_is_unsigned,
    output logic [3:0] alu_op,
    output logic [4:0] shamt,
    output logic       bgt,
    output logic       beq,
    output logic       blt,
    output logic       rt_is_zero,
    output logic       link_reg,
    output logic       is_trap,
    output logic       is_mf_hi,
    output logic       is_mf_lo,
    output logic       md_start,
    output logic       hilo_busy,
    output logic       md_done
);
    localparam int SQ_W = (TRAP_SQUASH > 0) ? $clog2(TRAP_SQUASH + 1) : 1;

    // ALU codes
    localparam logic [3:0] ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3, ALU_XOR  = 4'h4, ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6, ALU_SLTU = 4'h7, ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9, ALU_SRA  = 4'hA, ALU_SLLV = 4'hC;
    localparam logic [3:0] ALU_SRLV = 4'hD, ALU_SRAV = 4'hE;

    typedef struct packed {
        logic       reg_write, mem_to_reg, mem_write, alu_src;
        logic       reg_dest, is_byte, syscall, imm_is_unsigned;
        logic [3:0] alu_op;
        logic [4:0] shamt;
        logic       bgt, beq, blt, rt_is_zero, link_reg, is_trap;
        logic       is_mf_hi, is_mf_lo, md_start;
    } bundle_t;

    typedef enum logic {IDLE, TRAP_DRAIN} state_t;

    bundle_t d, sq, q;
    state_t state;
    logic illegal, hilo_user, is_div, accept, squashing, enter_drain;
    logic [CNT_W-1:0] cnt;
    logic [SQ_W-1:0] squash_cnt;

    always_comb begin
        d = '0;
        illegal = 1'b0;
        hilo_user = 1'b0;
        is_div = 1'b0;
        d.shamt = instr_shamt;
        case (opcode)
            6'h00: begin
                d.reg_dest = 1'b1;
                d.reg_write = 1'b1;
                case (funct)
                    6'h00: d.alu_op = ALU_SLL;
                    6'h02: d.alu_op = ALU_SRL;
                    6'h03: d.alu_op = ALU_SRA;
                    6'h04: d.alu_op = ALU_SLLV;
                    6'h06: d.alu_op = ALU_SRLV;
                    6'h07: d.alu_op = ALU_SRAV;
                    6'h0C: begin d.reg_write = 1'b0; d.syscall = 1'b1; end
                    6'h10: begin d.is_mf_hi = 1'b1; hilo_user = 1'b1; end
                    6'h12: begin d.is_mf_lo = 1'b1; hilo_user = 1'b1; end
                    6'h11, 6'h13: begin d.reg_write = 1'b0; hilo_user = 1'b1; end
                    6'h18, 6'h19: begin
                        d.reg_write = 1'b0; d.md_start = 1'b1; hilo_user = 1'b1;
                    end
                    6'h1A, 6'h1B: begin
                        d.reg_write = 1'b0; d.md_start = 1'b1; hilo_user = 1'b1;
                        is_div = 1'b1;
                    end
                    6'h20, 6'h21: d.alu_op = ALU_ADD;
                    6'h22, 6'h23: d.alu_op = ALU_SUB;
                    6'h24: d.alu_op = ALU_AND;
                    6'h25: d.alu_op = ALU_OR;
                    6'h26: d.alu_op = ALU_XOR;
                    6'h27: d.alu_op = ALU_NOR;
                    6'h2A: d.alu_op = ALU_SLT;
                    6'h2B: d.alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            6'h01: begin
                d.alu_op = ALU_SUB;
                d.rt_is_zero = 1'b1;
                case (reg_rt_id)
                    5'h00: d.blt = 1'b1;
                    5'h01: begin d.bgt = 1'b1; d.beq = 1'b1; end
                    5'h10: begin
                        d.blt = 1'b1; d.link_reg = 1'b1; d.reg_write = 1'b1;
                    end
                    5'h11: begin
                        d.bgt = 1'b1; d.beq = 1'b1;
                        d.link_reg = 1'b1; d.reg_write = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            // J/JAL are unconditional: every comparison outcome is taken
            6'h02: begin d.bgt = 1'b1; d.beq = 1'b1; d.blt = 1'b1; end
            6'h03: begin
                d.bgt = 1'b1; d.beq = 1'b1; d.blt = 1'b1;
                d.link_reg = 1'b1; d.reg_write = 1'b1;
            end
            6'h04: begin d.alu_op = ALU_SUB; d.beq = 1'b1; end
            6'h05: begin d.alu_op = ALU_SUB; d.bgt = 1'b1; d.blt = 1'b1; end
            6'h06: begin
                d.alu_op = ALU_SUB; d.rt_is_zero = 1'b1;
                d.blt = 1'b1; d.beq = 1'b1;
            end
            6'h07: begin
                d.alu_op = ALU_SUB; d.rt_is_zero = 1'b1; d.bgt = 1'b1;
            end
            6'h08, 6'h09: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1; d.alu_op = ALU_ADD;
            end
            6'h0A: begin d.reg_write = 1'b1; d.alu_src = 1'b1; d.alu_op = ALU_SLT; end
            6'h0B: begin d.reg_write = 1'b1; d.alu_src = 1'b1; d.alu_op = ALU_SLTU; end
            6'h0C: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1;
                d.imm_is_unsigned = 1'b1; d.alu_op = ALU_AND;
            end
            6'h0D: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1;
                d.imm_is_unsigned = 1'b1; d.alu_op = ALU_OR;
            end
            6'h0E: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1;
                d.imm_is_unsigned = 1'b1; d.alu_op = ALU_XOR;
            end
            // LUI is the immediate shifted left by 16
            6'h0F: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1;
                d.alu_op = ALU_SLL; d.shamt = 5'd16;
            end
            6'h20: begin
                d.reg_write = 1'b1; d.mem_to_reg = 1'b1;
                d.alu_src = 1'b1; d.is_byte = 1'b1;
            end
            6'h23: begin d.reg_write = 1'b1; d.mem_to_reg = 1'b1; d.alu_src = 1'b1; end
            6'h28: begin d.mem_write = 1'b1; d.alu_src = 1'b1; d.is_byte = 1'b1; end
            6'h2B: begin d.mem_write = 1'b1; d.alu_src = 1'b1; end
            // SWL is repurposed as the trap instruction
            6'h2A: begin
                d.is_trap = 1'b1; d.link_reg = 1'b1;
                d.bgt = 1'b1; d.beq = 1'b1; d.blt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            d = '0;
            hilo_user = 1'b0;
            is_div = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            d.is_trap = 1'b1; d.link_reg = 1'b1;
            d.bgt = 1'b1; d.beq = 1'b1; d.blt = 1'b1;
`endif
        end
    end

    // Squashed instructions keep datapath fields but lose every side effect
    always_comb begin
        sq = d;
        sq.reg_write = 1'b0; sq.mem_to_reg = 1'b0; sq.mem_write = 1'b0;
        sq.syscall = 1'b0; sq.bgt = 1'b0; sq.beq = 1'b0; sq.blt = 1'b0;
        sq.rt_is_zero = 1'b0; sq.link_reg = 1'b0; sq.is_trap = 1'b0;
        sq.is_mf_hi = 1'b0; sq.is_mf_lo = 1'b0; sq.md_start = 1'b0;
    end

    assign hilo_busy = (cnt != '0);
    assign stall_out = instr_valid & hilo_user & hilo_busy;
    assign accept = instr_valid & ~stall_out & ~stall_in & ~flush;
    assign squashing = (state == TRAP_DRAIN);
    assign enter_drain = d.is_trap & (TRAP_SQUASH > 0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            squash_cnt <= '0;
            cnt <= '0;
            md_done <= 1'b0;
            ctrl_valid <= 1'b0;
            q <= '0;
        end else begin
            // HI/LO occupancy runs independently of stall_in and flush
            if (accept && d.md_start)
                cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            md_done <= (cnt == CNT_W'(1));

            if (flush) begin
                ctrl_valid <= 1'b0;
                state <= IDLE;
                squash_cnt <= '0;
            end else if (stall_in) begin
                ctrl_valid <= ctrl_valid;
            end else if (accept) begin
                if (squashing) begin
                    q <= sq;
                    ctrl_valid <= 1'b0;
                    squash_cnt <= squash_cnt - 1'b1;
                    if (squash_cnt == SQ_W'(1))
                        state <= IDLE;
                end else begin
                    q <= d;
                    ctrl_valid <= 1'b1;
                    if (enter_drain) begin
                        state <= TRAP_DRAIN;
                        squash_cnt <= SQ_W'(TRAP_SQUASH);
                    end
                end
            end else begin
                ctrl_valid <= 1'b0;
            end
        end
    end

    assign reg_write = q.reg_write;
    assign mem_to_reg = q.mem_to_reg;
    assign mem_write = q.mem_write;
    assign alu_src = q.alu_src;
    assign reg_dest = q.reg_dest;
    assign is_byte = q.is_byte;
    assign syscall = q.syscall;
    assign imm_is_unsigned = q.imm_is_unsigned;
    assign alu_op = q.alu_op;
    assign shamt = q.shamt;
    assign bgt = q.bgt;
    assign beq = q.beq;
    assign blt = q.blt;
    assign rt_is_zero = q.rt_is_zero;
    assign link_reg = q.link_reg;
    assign is_trap = q.is_trap;
    assign is_mf_hi = q.is_mf_hi;
    assign is_mf_lo = q.is_mf_lo;
    assign md_start = q.md_start;
endmodule
